// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL control / reset sequencing logic:
// state encoding, default timing constants and small output-decode helpers.
package pll_ctrl_pkg;

    // Sequencer states; encoding is fixed so debug tools can decode it.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        PLL_RST   = 3'd1,
        STABLE    = 3'd2,
        REL_MEM   = 3'd3,
        RUN       = 3'd4
    } pll_state_e;

    // Default timing constants (cycles of the board clock).
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP     = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_ARESET_CYCLES = 8;
    localparam int DEF_CNT_W         = 17;

    // Ceiling of the lock-loss statistic.
    localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

    // Saturating increment for the 8-bit lock-loss statistic.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == LOSS_CNT_MAX) begin
            result = LOSS_CNT_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // Memories are out of reset in REL_MEM and RUN.
    function automatic logic mem_released(input pll_state_e s);
        logic result;
        case (s)
            REL_MEM: result = 1'b1;
            RUN:     result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // The CPU is out of reset only in RUN.
    function automatic logic cpu_released(input pll_state_e s);
        logic result;
        case (s)
            RUN:     result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // The PLL reset pin is driven only in PLL_RST.
    function automatic logic areset_active(input pll_state_e s);
        logic result;
        case (s)
            PLL_RST: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for signals that are asynchronous to clk.
// STAGES flops in series (at least two), cleared by the async active-low reset.
// Output is the input delayed by STAGES clock edges.
module sync_2ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 captures the asynchronous input; later stages settle metastability.
    logic [STAGES-1:0][WIDTH-1:0] stage_r;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {(STAGES*WIDTH){1'b0}};
        end else begin
            stage_r <= {stage_r[STAGES-2:0], d};
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor and system reset sequencer.
// Waits for a synchronized PLL lock, pulses the PLL reset if lock does not
// arrive in time, requires lock to hold for STABLE_CYCLES before releasing the
// memory reset, then releases the CPU reset STAGE_GAP cycles later. Any lock
// drop re-asserts both resets on the same edge that leaves the active state.
// All outputs come straight from flops.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int ARESET_CYCLES = DEF_ARESET_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_areset,
    output logic       mem_rst_n,
    output logic       cpu_rst_n,
    output logic       sys_ready,
    output logic [7:0] lock_loss_cnt
);

    // Counter constants; each terminal value is the last count of a state.
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    logic             lk_s;
    pll_state_e       state_r;
    pll_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [7:0]       loss_cnt_r;
    logic [7:0]       loss_cnt_s;
    logic             pll_areset_r;
    logic             pll_areset_s;
    logic             mem_rst_n_r;
    logic             mem_rst_n_s;
    logic             cpu_rst_n_r;
    logic             cpu_rst_n_s;
    logic             sys_ready_r;
    logic             sys_ready_s;

    sync_2ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Next-state, shared counter and lock-loss statistic; a lock drop takes
    // priority over any counter terminal value.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + CNT_ONE;
        loss_cnt_s = loss_cnt_r;
        case (state_r)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_s = STABLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s = PLL_RST;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            PLL_RST: begin
                // Lock status is meaningless while the PLL is held in reset.
                if (cnt_r == ARESET_LAST) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = PLL_RST;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_s = REL_MEM;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = STABLE;
                end
            end
            REL_MEM: begin
                if (!lk_s) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == GAP_LAST) begin
                    state_s = RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = REL_MEM;
                end
            end
            RUN: begin
                // The counter is parked at zero here so it cannot wrap.
                cnt_s = CNT_ZERO;
                if (!lk_s) begin
                    state_s    = WAIT_LOCK;
                    loss_cnt_s = sat_inc8(loss_cnt_r);
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = WAIT_LOCK;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values are decoded from the next state so every output flop
    // changes on the same edge as the state register.
    always_comb begin
        pll_areset_s = areset_active(state_s);
        mem_rst_n_s  = mem_released(state_s);
        cpu_rst_n_s  = cpu_released(state_s);
        sys_ready_s  = cpu_released(state_s);
    end

    // State, counter, statistic and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= WAIT_LOCK;
            cnt_r        <= CNT_ZERO;
            loss_cnt_r   <= 8'd0;
            pll_areset_r <= 1'b0;
            mem_rst_n_r  <= 1'b0;
            cpu_rst_n_r  <= 1'b0;
            sys_ready_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            loss_cnt_r   <= loss_cnt_s;
            pll_areset_r <= pll_areset_s;
            mem_rst_n_r  <= mem_rst_n_s;
            cpu_rst_n_r  <= cpu_rst_n_s;
            sys_ready_r  <= sys_ready_s;
        end
    end

    assign pll_areset    = pll_areset_r;
    assign mem_rst_n     = mem_rst_n_r;
    assign cpu_rst_n     = cpu_rst_n_r;
    assign sys_ready     = sys_ready_r;
    assign lock_loss_cnt = loss_cnt_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters.
// A run-length model (how long lock has been continuously seen, how long the
// bench has waited without lock, how much of a PLL reset pulse remains)
// predicts every output each cycle; directed scenarios add literal checkpoints.
module tb_pll_reset_sequencer;

    localparam int S = 8;   // STABLE_CYCLES
    localparam int G = 4;   // STAGE_GAP
    localparam int T = 32;  // LOCK_TIMEOUT
    localparam int A = 3;   // ARESET_CYCLES

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_areset;
    logic       mem_rst_n;
    logic       cpu_rst_n;
    logic       sys_ready;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .LOCK_TIMEOUT  (T),
        .ARESET_CYCLES (A),
        .CNT_W         (17)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_areset    (pll_areset),
        .mem_rst_n     (mem_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .sys_ready     (sys_ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_sync0 = 1'b0;
    bit m_sync1 = 1'b0;
    int m_areset_left = 0;  // remaining cycles of PLL reset pulse
    int m_wait = 0;         // cycles waited without lock
    int m_lock_len = 0;     // consecutive locked cycles (capped once running)
    int m_loss = 0;

    task automatic model_reset();
        m_sync0 = 1'b0;
        m_sync1 = 1'b0;
        m_areset_left = 0;
        m_wait = 0;
        m_lock_len = 0;
        m_loss = 0;
    endtask

    task automatic model_step();
        bit lk;
        lk = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = pll_locked;
        if (m_areset_left > 0) begin
            m_areset_left--;
            m_wait = 0;
        end else if (m_lock_len > 0) begin
            if (!lk) begin
                if (m_lock_len >= S + G + 1 && m_loss < 255) m_loss++;
                m_lock_len = 0;
                m_wait = 0;
            end else if (m_lock_len < S + G + 1) begin
                m_lock_len++;
            end
        end else if (lk) begin
            m_lock_len = 1;
        end else begin
            m_wait++;
            if (m_wait == T) begin
                m_areset_left = A;
                m_wait = 0;
            end
        end
    endtask

    // Model update on every edge and full output comparison 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            check("areset_vs_model", {31'd0, pll_areset}, {31'd0, m_areset_left > 0});
            check("mem_vs_model", {31'd0, mem_rst_n}, {31'd0, m_lock_len >= S + 1});
            check("cpu_vs_model", {31'd0, cpu_rst_n}, {31'd0, m_lock_len >= S + G + 1});
            check("ready_vs_model", {31'd0, sys_ready}, {31'd0, m_lock_len >= S + G + 1});
            check("loss_vs_model", {24'd0, lock_loss_cnt}, m_loss);
            check("inv_cpu_implies_mem", {31'd0, (!cpu_rst_n) || mem_rst_n}, 32'd1);
            check("inv_areset_implies_mem_low", {31'd0, (!pll_areset) || (!mem_rst_n)}, 32'd1);
            check("inv_ready_eq_cpu", {31'd0, sys_ready == cpu_rst_n}, 32'd1);
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Advance n rising edges, then settle 2 ns past the last one.
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Hold reset for 3 edges with lock low, check reset values, release.
    // The next rising edge after return is edge 1.
    task automatic apply_reset();
        rst_n = 1'b0;
        pll_locked = 1'b0;
        go(3);
        check("rst_areset", {31'd0, pll_areset}, 32'd0);
        check("rst_mem", {31'd0, mem_rst_n}, 32'd0);
        check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_ready", {31'd0, sys_ready}, 32'd0);
        check("rst_loss", {24'd0, lock_loss_cnt}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit stuck;

        // 1: lock after edge 5 -> mem at edge 16, cpu/ready at edge 20
        apply_reset();
        go(5);  pll_locked = 1'b1;
        go(10); check("t1_mem_e15", {31'd0, mem_rst_n}, 32'd0);
        go(1);  check("t1_mem_e16", {31'd0, mem_rst_n}, 32'd1);
                check("t1_cpu_e16", {31'd0, cpu_rst_n}, 32'd0);
        go(3);  check("t1_cpu_e19", {31'd0, cpu_rst_n}, 32'd0);
        go(1);  check("t1_cpu_e20", {31'd0, cpu_rst_n}, 32'd1);
                check("t1_ready_e20", {31'd0, sys_ready}, 32'd1);
                check("t1_areset_e20", {31'd0, pll_areset}, 32'd0);

        // 3: one-cycle lock drop in RUN (low after edge 25, high after 26)
        go(5);  pll_locked = 1'b0;
        go(1);  pll_locked = 1'b1;
        go(1);  check("t3_cpu_e27", {31'd0, cpu_rst_n}, 32'd1);
        go(1);  check("t3_cpu_e28", {31'd0, cpu_rst_n}, 32'd0);
                check("t3_mem_e28", {31'd0, mem_rst_n}, 32'd0);
                check("t3_loss_e28", {24'd0, lock_loss_cnt}, 32'd1);
        go(8);  check("t3_mem_e36", {31'd0, mem_rst_n}, 32'd0);
        go(1);  check("t3_mem_e37", {31'd0, mem_rst_n}, 32'd1);

        // 2: no lock -> areset high at edges 32..34, again from 67
        apply_reset();
        go(31); check("t2_areset_e31", {31'd0, pll_areset}, 32'd0);
        go(1);  check("t2_areset_e32", {31'd0, pll_areset}, 32'd1);
        go(2);  check("t2_areset_e34", {31'd0, pll_areset}, 32'd1);
        go(1);  check("t2_areset_e35", {31'd0, pll_areset}, 32'd0);
        go(31); check("t2_areset_e66", {31'd0, pll_areset}, 32'd0);
        go(1);  check("t2_areset_e67", {31'd0, pll_areset}, 32'd1);
                check("t2_mem_e67", {31'd0, mem_rst_n}, 32'd0);

        // 4: glitch seen by the FSM at STABLE count 5 -> fresh count, mem at 23
        apply_reset();
        go(5);  pll_locked = 1'b1;
        go(6);  pll_locked = 1'b0;
        go(1);  pll_locked = 1'b1;
        go(4);  check("t4_mem_e16", {31'd0, mem_rst_n}, 32'd0);
                check("t4_loss_e16", {24'd0, lock_loss_cnt}, 32'd0);
        go(6);  check("t4_mem_e22", {31'd0, mem_rst_n}, 32'd0);
        go(1);  check("t4_mem_e23", {31'd0, mem_rst_n}, 32'd1);

        // 5: async reset while in REL_MEM, then clean restart with lock held high
        apply_reset();
        go(5);  pll_locked = 1'b1;
        go(12); check("t5_mem_e17", {31'd0, mem_rst_n}, 32'd1);
        #5 rst_n = 1'b0;
        #1 check("t5_mem_async", {31'd0, mem_rst_n}, 32'd0);
           check("t5_cpu_async", {31'd0, cpu_rst_n}, 32'd0);
        go(2);  rst_n = 1'b1;
        go(10); check("t5_mem_r10", {31'd0, mem_rst_n}, 32'd0);
        go(1);  check("t5_mem_r11", {31'd0, mem_rst_n}, 32'd1);
        go(3);  check("t5_cpu_r14", {31'd0, cpu_rst_n}, 32'd0);
        go(1);  check("t5_cpu_r15", {31'd0, cpu_rst_n}, 32'd1);

        // 6: 300 lock drops in RUN -> statistic saturates at 255
        apply_reset();
        pll_locked = 1'b1;
        stuck = 1'b0;
        for (int i = 0; i < 300 && !stuck; i++) begin
            n = 0;
            while (!sys_ready && n < 50) begin
                go(1);
                n++;
            end
            if (!sys_ready) begin
                check("t6_reach_run", {31'd0, sys_ready}, 32'd1);
                stuck = 1'b1;
            end else begin
                pll_locked = 1'b0;
                go(1);
                pll_locked = 1'b1;
                go(2);
                if (i == 254) check("t6_loss_255th", {24'd0, lock_loss_cnt}, 32'd255);
            end
        end
        go(20);
        check("t6_loss_saturated", {24'd0, lock_loss_cnt}, 32'd255);
        check("t6_ready_again", {31'd0, sys_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
